// File: rtl/z80_dma_ctrl.sv
// z80_dma_ctrl: bus-mastering block-copy controller for the tv80s environment.
//
// Requests the Z80 bus (busrq_n/busak_n), copies len bytes from src_addr to
// dst_addr over the shared memory bus, then returns the bus to the CPU.
// Every output is registered, so the value seen during a state is set up on
// the clock edge that enters that state.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, abort          command pulse / stop-after-current-byte request
//   src_addr, dst_addr    transfer start addresses
//   len                   byte count (0 = no transfer)
//   busy, done, aborted   status; aborted is valid while done is high
//   busrq_n, busak_n      CPU bus request / acknowledge
//   dma_owns_bus          high while the DMA drives the memory bus
//   mem_a, mem_do, mem_di memory address, write data, read data
//   mem_mreq_n, mem_rd_n, mem_wr_n  memory strobes
//
// Optional build macro DMA_FILL_EN adds fill_mode/fill_data: each byte becomes
// a single write cycle of fill_data to dst, with no reads.
module z80_dma_ctrl #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
`ifdef DMA_FILL_EN
  input  logic              fill_mode,
  input  logic [7:0]        fill_data,
`endif
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              busrq_n,
  input  logic              busak_n,
  output logic              dma_owns_bus,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_do,
  input  logic [7:0]        mem_di,
  output logic              mem_mreq_n,
  output logic              mem_rd_n,
  output logic              mem_wr_n
);

  typedef enum logic [2:0] {StIdle, StReq, StRd, StRdw, StWr, StRel, StFin} state_e;

  localparam logic [2:0]        LatInit = 3'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] One     = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [2:0]        lat_q, lat_d;
  logic              abort_pend_q, abort_pend_d;
  logic              early_q, early_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              busrq_n_q, busrq_n_d;
  logic              owns_q, owns_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_do_q, mem_do_d;
  logic              mreq_n_q, mreq_n_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic              abort_now;
  logic              fill_active;

`ifdef DMA_FILL_EN
  logic fill_q, fill_d;
  assign fill_active = fill_q;
`else
  assign fill_active = 1'b0;
`endif

  assign abort_now = abort_pend_q | abort;

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    cnt_d        = cnt_q;
    lat_d        = lat_q;
    early_d      = early_q;
    busy_d       = busy_q;
    busrq_n_d    = busrq_n_q;
    owns_d       = owns_q;
    mem_a_d      = mem_a_q;
    mem_do_d     = mem_do_q;
    mreq_n_d     = mreq_n_q;
    rd_n_d       = rd_n_q;
    wr_n_d       = wr_n_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    // abort is ignored in IDLE, including in the cycle a start is accepted
    abort_pend_d = (state_q == StIdle) ? 1'b0 : abort_now;
`ifdef DMA_FILL_EN
    fill_d       = fill_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          early_d = 1'b0;
          if (len != '0) begin
            src_d     = src_addr;
            dst_d     = dst_addr;
            cnt_d     = len;
            busy_d    = 1'b1;
            busrq_n_d = 1'b0;
            state_d   = StReq;
`ifdef DMA_FILL_EN
            fill_d    = fill_mode;
            // The data register doubles as the fill pattern holder.
            if (fill_mode) mem_do_d = fill_data;
`endif
          end else begin
            state_d = StFin;
          end
        end
      end

      StReq: begin
        if (abort_now) begin
          early_d   = 1'b1;
          busrq_n_d = 1'b1;
          state_d   = StRel;
        end else if (!busak_n) begin
          owns_d   = 1'b1;
          mreq_n_d = 1'b0;
          if (fill_active) begin
            mem_a_d = dst_q;
            wr_n_d  = 1'b0;
            state_d = StWr;
          end else begin
            mem_a_d = src_q;
            rd_n_d  = 1'b0;
            state_d = StRd;
          end
        end
      end

      StRd: begin
        lat_d   = LatInit;
        state_d = StRdw;
      end

      StRdw: begin
        if (lat_q == '0) begin
          mem_do_d = mem_di;
          mem_a_d  = dst_q;
          rd_n_d   = 1'b1;
          wr_n_d   = 1'b0;
          state_d  = StWr;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end

      StWr: begin
        src_d  = fill_active ? src_q : src_q + One;
        dst_d  = dst_q + One;
        cnt_d  = cnt_q - One;
        wr_n_d = 1'b1;
        if (cnt_q == One || abort_now) begin
          // Only an abort with bytes still outstanding counts as early.
          early_d   = (cnt_q != One);
          mreq_n_d  = 1'b1;
          owns_d    = 1'b0;
          busrq_n_d = 1'b1;
          state_d   = StRel;
        end else if (fill_active) begin
          mem_a_d = dst_q + One;
          wr_n_d  = 1'b0;
        end else begin
          // mreq_n stays low between bytes; only rd/wr toggle.
          mem_a_d = src_q + One;
          rd_n_d  = 1'b0;
          state_d = StRd;
        end
      end

      StRel: begin
        if (busak_n) state_d = StFin;
      end

      StFin: begin
        done_d    = 1'b1;
        aborted_d = early_q;
        busy_d    = 1'b0;
        state_d   = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      src_q        <= '0;
      dst_q        <= '0;
      cnt_q        <= '0;
      lat_q        <= '0;
      abort_pend_q <= 1'b0;
      early_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      busrq_n_q    <= 1'b1;
      owns_q       <= 1'b0;
      mem_a_q      <= '0;
      mem_do_q     <= '0;
      mreq_n_q     <= 1'b1;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
`ifdef DMA_FILL_EN
      fill_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      cnt_q        <= cnt_d;
      lat_q        <= lat_d;
      abort_pend_q <= abort_pend_d;
      early_q      <= early_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      busrq_n_q    <= busrq_n_d;
      owns_q       <= owns_d;
      mem_a_q      <= mem_a_d;
      mem_do_q     <= mem_do_d;
      mreq_n_q     <= mreq_n_d;
      rd_n_q       <= rd_n_d;
      wr_n_q       <= wr_n_d;
`ifdef DMA_FILL_EN
      fill_q       <= fill_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign busrq_n      = busrq_n_q;
  assign dma_owns_bus = owns_q;
  assign mem_a        = mem_a_q;
  assign mem_do       = mem_do_q;
  assign mem_mreq_n   = mreq_n_q;
  assign mem_rd_n     = rd_n_q;
  assign mem_wr_n     = wr_n_q;

endmodule

// File: tb/tb_z80_dma_ctrl.sv
// Self-checking bench for z80_dma_ctrl: 64 KB memory model with a one-clock
// registered read, a CPU stand-in whose busak_n follows busrq_n after two
// clocks, and a write scoreboard fed when each transfer is started.
module tb_z80_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset_n, start, abort;
  logic [15:0] src_addr, dst_addr, len;
  logic        busy, done, aborted, busrq_n, busak_n, dma_owns_bus;
  logic [15:0] mem_a;
  logic [7:0]  mem_do, mem_di;
  logic        mem_mreq_n, mem_rd_n, mem_wr_n;
`ifdef DMA_FILL_EN
  logic        fill_mode;
  logic [7:0]  fill_data;
`endif

  logic [7:0]  mem [0:65535];
  logic [1:0]  busak_pipe;
  logic        hold_grant;
  logic [23:0] exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_writes = 0;
  int          n_done   = 0;
  int          n_busrq  = 0;

  always #5 clk = ~clk;

  z80_dma_ctrl #(.RD_LAT(1), .ADDR_W(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .len          (len),
`ifdef DMA_FILL_EN
    .fill_mode    (fill_mode),
    .fill_data    (fill_data),
`endif
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .busrq_n      (busrq_n),
    .busak_n      (busak_n),
    .dma_owns_bus (dma_owns_bus),
    .mem_a        (mem_a),
    .mem_do       (mem_do),
    .mem_di       (mem_di),
    .mem_mreq_n   (mem_mreq_n),
    .mem_rd_n     (mem_rd_n),
    .mem_wr_n     (mem_wr_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // CPU stand-in: grant follows the request two clocks later.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) busak_pipe <= 2'b11;
    else          busak_pipe <= {busak_pipe[0], busrq_n};
  end
  assign busak_n = hold_grant | busak_pipe[1];

  // Read data valid one clock after the read strobe.
  always @(posedge clk) mem_di <= (!mem_mreq_n && !mem_rd_n) ? mem[mem_a] : 8'h00;

  // Write monitor and scoreboard.
  always @(negedge clk) begin
    logic [23:0] e;
    if (reset_n) begin
      if (!busrq_n) n_busrq++;
      if (done) n_done++;
      if (!mem_mreq_n && !mem_wr_n) begin
        n_writes++;
        mem[mem_a] <= mem_do;
        check("sb_write_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_owns_addr_data", {7'b0, dma_owns_bus, mem_a, mem_do}, {8'h01, e});
        end
      end
    end
  end

  task automatic do_start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                          input bit push);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    len      = l;
    start    = 1'b1;
    if (push) for (int i = 0; i < int'(l); i++) exp_q.push_back({d + 16'(i), mem[s + 16'(i)]});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output logic ab,
                           output int busy_gaps);
    bit seen;
    seen      = 1'b0;
    ab        = 1'b0;
    busy_gaps = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        ab   = aborted;
      end else if (!busy) begin
        busy_gaps++;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ab;
    int   gaps, base_wr, base_done, base_rq, seen, run;

    reset_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    src_addr   = '0;
    dst_addr   = '0;
    len        = '0;
    hold_grant = 1'b0;
`ifdef DMA_FILL_EN
    fill_mode  = 1'b0;
    fill_data  = 8'h00;
`endif
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_busrq_n", 32'(busrq_n), 32'd1);
    check("rst_mreq_n", 32'(mem_mreq_n), 32'd1);
    check("rst_rd_n", 32'(mem_rd_n), 32'd1);
    check("rst_wr_n", 32'(mem_wr_n), 32'd1);
    check("rst_mem_a", 32'(mem_a), 32'd0);
    check("rst_mem_do", 32'(mem_do), 32'd0);
    check("rst_busy_done_ab_owns", {28'd0, busy, done, aborted, dma_owns_bus}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic copy, with a stray start while busy
    mem[16'h8000] = 8'h11; mem[16'h8001] = 8'h22; mem[16'h8002] = 8'h33; mem[16'h8003] = 8'h44;
    base_wr   = n_writes;
    base_done = n_done;
    do_start(16'h8000, 16'h9000, 16'd4, 1'b1);
    check("basic_busy", 32'(busy), 32'd1);
    check("basic_busrq_low", 32'(busrq_n), 32'd0);
    src_addr = 16'h0000; dst_addr = 16'h0000; len = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("basic", 100, ab, gaps);
    check("basic_aborted", 32'(ab), 32'd0);
    check("basic_busy_gaps", 32'(gaps), 32'd0);
    repeat (3) @(negedge clk);
    check("basic_one_done", 32'(n_done - base_done), 32'd1);
    check("basic_busrq_back", 32'(busrq_n), 32'd1);
    check("basic_nwrites", 32'(n_writes - base_wr), 32'd4);
    check("basic_sb_empty", 32'(exp_q.size()), 32'd0);
    check("basic_mem", {mem[16'h9000], mem[16'h9001], mem[16'h9002], mem[16'h9003]},
          32'h11223344);

    // Zero length
    base_wr = n_writes;
    base_rq = n_busrq;
    do_start(16'h8000, 16'h9100, 16'd0, 1'b0);
    check("zero_done_not_early", 32'(done), 32'd0);
    @(negedge clk);
    check("zero_done_2clk", {30'd0, done, aborted}, 32'd2);
    repeat (3) @(negedge clk);
    check("zero_no_busrq", 32'(n_busrq - base_rq), 32'd0);
    check("zero_no_writes", 32'(n_writes - base_wr), 32'd0);

    // Address wrap
    mem[16'hFFFE] = 8'hAA; mem[16'hFFFF] = 8'hBB; mem[16'h0000] = 8'hCC;
    do_start(16'hFFFE, 16'h0010, 16'd3, 1'b1);
    wait_done("wrap", 100, ab, gaps);
    repeat (3) @(negedge clk);
    check("wrap_mem", {8'h00, mem[16'h0010], mem[16'h0011], mem[16'h0012]}, 32'h00AABBCC);
    check("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

    // Abort during the RDW of the third byte
    for (int i = 0; i < 10; i++) mem[16'h8000 + 16'(i)] = 8'h40 + 8'(i);
    base_wr = n_writes;
    do_start(16'h8000, 16'hB000, 16'd10, 1'b0);
    for (int i = 0; i < 3; i++) exp_q.push_back({16'hB000 + 16'(i), 8'h40 + 8'(i)});
    seen = 0;
    for (int i = 0; i < 200 && seen < 2; i++) begin
      @(negedge clk);
      if (!mem_wr_n && !mem_mreq_n) seen++;
    end
    check("abort_two_writes_seen", 32'(seen), 32'd2);
    @(negedge clk);
    check("abort_rd_phase", 32'(mem_rd_n), 32'd0);
    @(negedge clk);
    check("abort_rdw_phase", 32'(mem_rd_n), 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort_rdw", 100, ab, gaps);
    check("abort_rdw_aborted", 32'(ab), 32'd1);
    repeat (3) @(negedge clk);
    check("abort_rdw_nwrites", 32'(n_writes - base_wr), 32'd3);
    check("abort_rdw_mem", {mem[16'hB000], mem[16'hB001], mem[16'hB002], mem[16'hB003]},
          32'h40414200);
    check("abort_rdw_busrq", 32'(busrq_n), 32'd1);
    check("abort_rdw_sb_empty", 32'(exp_q.size()), 32'd0);

    // Abort in REQ before the grant
    hold_grant = 1'b1;
    base_wr    = n_writes;
    do_start(16'h8000, 16'hE000, 16'd5, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort_req", 50, ab, gaps);
    check("abort_req_aborted", 32'(ab), 32'd1);
    hold_grant = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_req_nwrites", 32'(n_writes - base_wr), 32'd0);
    check("abort_req_busrq", 32'(busrq_n), 32'd1);

    // Reset during WR, then a normal transfer
    do_start(16'h8000, 16'hC000, 16'd4, 1'b1);
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(negedge clk);
      if (!mem_wr_n) seen = 1;
    end
    check("rstmid_wr_seen", 32'(seen), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstmid_strobes", {29'd0, busrq_n, mem_wr_n, mem_mreq_n}, 32'd7);
    check("rstmid_busy_owns", {30'd0, busy, dma_owns_bus}, 32'd0);
    @(negedge clk);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) mem[16'h8100 + 16'(i)] = 8'hA1 + 8'(i);
    do_start(16'h8100, 16'hD000, 16'd4, 1'b1);
    wait_done("rstmid_after", 100, ab, gaps);
    check("rstmid_after_aborted", 32'(ab), 32'd0);
    repeat (3) @(negedge clk);
    check("rstmid_after_mem", {mem[16'hD000], mem[16'hD001], mem[16'hD002], mem[16'hD003]},
          32'hA1A2A3A4);
    check("rstmid_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef DMA_FILL_EN
    // Fill mode
    fill_mode = 1'b1;
    fill_data = 8'h5A;
    for (int i = 0; i < 8; i++) exp_q.push_back({16'hA000 + 16'(i), 8'h5A});
    do_start(16'h1234, 16'hA000, 16'd8, 1'b0);
    fill_mode = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      if (!mem_wr_n && !mem_mreq_n) seen = 1;
      else @(negedge clk);
    end
    run = 0;
    for (int i = 0; i < 20 && !mem_wr_n && !mem_mreq_n; i++) begin
      run++;
      @(negedge clk);
    end
    check("fill_consecutive_wr", 32'(run), 32'd8);
    wait_done("fill", 50, ab, gaps);
    repeat (3) @(negedge clk);
    check("fill_mem_lo", {mem[16'hA000], mem[16'hA001], mem[16'hA002], mem[16'hA003]},
          32'h5A5A5A5A);
    check("fill_mem_hi", {mem[16'hA004], mem[16'hA005], mem[16'hA006], mem[16'hA007]},
          32'h5A5A5A5A);
    check("fill_sb_empty", 32'(exp_q.size()), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
